// File: rtl/vc_scheduler_if.sv
// Bus between the VC/D FIFO pair and the weighted round-robin scheduler.
// The scheduler sits on the slave modport; the FIFO side uses master.
interface vc_scheduler_if #(
    parameter int DATA_SIZE = 6
);
    logic                 enable;
    logic                 fifo_empty_vc0;
    logic                 fifo_empty_vc1;
    logic [DATA_SIZE-1:0] data_vc0_head;
    logic [DATA_SIZE-1:0] data_vc1_head;
    logic                 fifo_pause_d0;
    logic                 fifo_pause_d1;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic                 push_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_out;
    logic [1:0]           grant_state;

    modport master (
        output enable, fifo_empty_vc0, fifo_empty_vc1, data_vc0_head, data_vc1_head,
               fifo_pause_d0, fifo_pause_d1,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out, grant_state
    );

    modport slave (
        input  enable, fifo_empty_vc0, fifo_empty_vc1, data_vc0_head, data_vc1_head,
               fifo_pause_d0, fifo_pause_d1,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out, grant_state
    );
endinterface

// File: rtl/vc_scheduler.sv
// Weighted round-robin pop scheduler for two VC FIFOs feeding two D FIFOs,
// with per-destination backpressure and a one-cycle registered push stage.
module vc_scheduler #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 4,
    parameter int WEIGHT0   = 3,
    parameter int WEIGHT1   = 1
) (
    input  logic          clk,
    input  logic          reset,
    vc_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_VC0 = 2'd1, S_VC1 = 2'd2} state_t;

    localparam logic [3:0] W0 = 4'(WEIGHT0);
    localparam logic [3:0] W1 = 4'(WEIGHT1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 push_d0_q, push_d1_q;
    logic [DATA_SIZE-1:0] data_q;

    logic dest0, dest1, elig0, elig1, gnt0, gnt1;

    assign dest0 = bus.data_vc0_head[DEST_BIT];
    assign dest1 = bus.data_vc1_head[DEST_BIT];

    // Reset masks eligibility so pops stay low while reset is held.
    assign elig0 = ~reset & bus.enable & ~bus.fifo_empty_vc0 &
                   ~(dest0 ? bus.fifo_pause_d1 : bus.fifo_pause_d0);
    assign elig1 = ~reset & bus.enable & ~bus.fifo_empty_vc1 &
                   ~(dest1 ? bus.fifo_pause_d1 : bus.fifo_pause_d0);

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        case (state_q)
            S_VC0: begin
                gnt0 = elig0 & ((cnt_q < W0) | ~elig1);
                gnt1 = ~gnt0 & elig1;
            end
            S_VC1: begin
                gnt1 = elig1 & ((cnt_q < W1) | ~elig0);
                gnt0 = ~gnt1 & elig0;
            end
            default: begin
                gnt0 = elig0;
                gnt1 = ~elig0 & elig1;
            end
        endcase
        if (gnt0) begin
            state_d = S_VC0;
            cnt_d   = (state_q != S_VC0) ? 4'd1 : (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else if (gnt1) begin
            state_d = S_VC1;
            cnt_d   = (state_q != S_VC1) ? 4'd1 : (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            push_d0_q <= 1'b0;
            push_d1_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            push_d0_q <= (gnt0 & ~dest0) | (gnt1 & ~dest1);
            push_d1_q <= (gnt0 & dest0) | (gnt1 & dest1);
            if (gnt0)
                data_q <= bus.data_vc0_head;
            else if (gnt1)
                data_q <= bus.data_vc1_head;
        end
    end

    assign bus.pop_vc0     = gnt0;
    assign bus.pop_vc1     = gnt1;
    assign bus.push_d0     = push_d0_q;
    assign bus.push_d1     = push_d1_q;
    assign bus.data_out    = data_q;
    assign bus.grant_state = state_q;
endmodule

// File: tb/tb_vc_scheduler.sv
// Bench for vc_scheduler: queue-based FIFO model with a run-length arbiter
// model checked every cycle, plus directed literal expectations.
module tb_vc_scheduler;
    localparam int DW = 6;
    localparam int W0 = 3;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vc_scheduler_if #(.DATA_SIZE(DW)) vif ();

    vc_scheduler #(.DATA_SIZE(DW), .DEST_BIT(4), .WEIGHT0(W0), .WEIGHT1(W1)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (vif.slave)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [7:0]    plog[$];
    logic en = 1'b0, p0 = 1'b0, p1 = 1'b0;
    bit   chk_on = 1'b0;

    // model state: last granted VC (0 none), length of its current run
    int            m_last = 0, m_run = 0;
    logic          m_push0 = 1'b0, m_push1 = 1'b0;
    logic [DW-1:0] m_data = '0;

    logic          s_pop0, s_pop1, s_push0, s_push1;
    logic [DW-1:0] s_data;
    logic [1:0]    s_gs;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [DW-1:0] w);
        return w[4] ? p1 : p0;
    endfunction

    task automatic cycle();
        bit e0, e1, g0, g1;
        logic [DW-1:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        vif.fifo_empty_vc0 = (q0.size() == 0);
        vif.fifo_empty_vc1 = (q1.size() == 0);
        vif.data_vc0_head  = h0;
        vif.data_vc1_head  = h1;
        vif.enable         = en;
        vif.fifo_pause_d0  = p0;
        vif.fifo_pause_d1  = p1;
        @(negedge clk);
        e0 = !rst && en && q0.size() > 0 && !blocked(h0);
        e1 = !rst && en && q1.size() > 0 && !blocked(h1);
        if (m_last == 1) begin
            g0 = e0 && (m_run < W0 || !e1);
            g1 = !g0 && e1;
        end else if (m_last == 2) begin
            g1 = e1 && (m_run < W1 || !e0);
            g0 = !g1 && e0;
        end else begin
            g0 = e0;
            g1 = !e0 && e1;
        end
        s_pop0 = vif.pop_vc0;   s_pop1 = vif.pop_vc1;
        s_push0 = vif.push_d0;  s_push1 = vif.push_d1;
        s_data = vif.data_out;  s_gs = vif.grant_state;
        if (chk_on) begin
            chk("pop_vc0", {7'd0, s_pop0}, {7'd0, g0});
            chk("pop_vc1", {7'd0, s_pop1}, {7'd0, g1});
            chk("push_d0", {7'd0, s_push0}, {7'd0, m_push0});
            chk("push_d1", {7'd0, s_push1}, {7'd0, m_push1});
            chk("data_out", {2'd0, s_data}, {2'd0, m_data});
            chk("grant_state", {6'd0, s_gs}, 8'(m_last));
        end
        if (s_push0 === 1'b1 || s_push1 === 1'b1) plog.push_back({s_push1, s_push0, s_data});
        @(posedge clk);
        if (rst) begin
            m_last = 0; m_run = 0; m_push0 = 1'b0; m_push1 = 1'b0; m_data = '0;
        end else if (g0) begin
            m_run = (m_last == 1) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_last = 1; m_push0 = !h0[4]; m_push1 = h0[4]; m_data = h0;
            void'(q0.pop_front());
        end else if (g1) begin
            m_run = (m_last == 2) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_last = 2; m_push0 = !h1[4]; m_push1 = h1[4]; m_data = h1;
            void'(q1.pop_front());
        end else begin
            m_last = 0; m_run = 0; m_push0 = 1'b0; m_push1 = 1'b0;
        end
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back(6'(i & 6'h1f));
            q1.push_back(6'(6'h20 | (i & 6'h17)));
        end
    endtask

    task automatic drain();
        q0.delete(); q1.delete();
        cycle(); cycle();
    endtask

    initial begin
        int n0, n1;
        logic [3:0] pat;
        en = 1'b1;
        cycle();
        chk_on = 1'b1;

        // 1: reset with both VCs non-empty
        fill(4);
        cycle();
        chk("rst_pops", {6'd0, s_pop1, s_pop0}, 8'd0);
        cycle();
        chk("rst_push", {6'd0, s_push1, s_push0}, 8'd0);
        chk("rst_data", {2'd0, s_data}, 8'd0);
        chk("rst_gs", {6'd0, s_gs}, 8'd0);
        rst = 1'b0;
        q0.delete(); q1.delete();
        cycle();

        // 2: VC0 alone, destinations from bit 4
        plog.delete();
        q0.push_back(6'h01); q0.push_back(6'h12); q0.push_back(6'h03);
        n0 = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n0 += int'(s_pop0);
        end
        chk("t2_pops", 8'(n0), 8'd3);
        chk("t2_npush", 8'(plog.size()), 8'd3);
        if (plog.size() == 3) begin
            chk("t2_push0", plog[0], 8'h41);
            chk("t2_push1", plog[1], 8'h92);
            chk("t2_push2", plog[2], 8'h43);
        end

        // 3: weighted share over 40 cycles
        fill(45);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n0 += int'(s_pop0);
            n1 += int'(s_pop1);
        end
        chk("t3_vc0", 8'(n0), 8'd30);
        chk("t3_vc1", 8'(n1), 8'd10);
        drain();

        // 4: paused destination does not block the other VC
        p1 = 1'b1;
        q0.push_back(6'h10); q1.push_back(6'h05);
        cycle();
        chk("t4_first", {6'd0, s_pop1, s_pop0}, 8'd2);
        n0 = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n0 += int'(s_pop0);
        end
        chk("t4_blocked", 8'(n0), 8'd0);
        p1 = 1'b0;
        cycle();
        chk("t4_release", {7'd0, s_pop0}, 8'd1);
        cycle();
        chk("t4_push", {s_push1, s_push0, s_data}, 8'h90);
        drain();

        // 5: enable drop mid-stream
        fill(20);
        for (int i = 0; i < 5; i++) cycle();
        en = 1'b0;
        cycle();
        chk("t5_nopop", {6'd0, s_pop1, s_pop0}, 8'd0);
        chk("t5_inflight", {7'd0, s_push0 | s_push1}, 8'd1);
        cycle();
        chk("t5_nopush", {6'd0, s_push1, s_push0}, 8'd0);
        chk("t5_idle", {6'd0, s_gs}, 8'd0);
        cycle();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pat[3-i] = s_pop1;
        end
        chk("t5_restart", {4'd0, pat}, 8'h01);
        drain();

        // 6: reset right after a VC0 pop
        fill(5);
        cycle();
        chk("t6_pop", {6'd0, s_pop1, s_pop0}, 8'd1);
        rst = 1'b1;
        cycle();
        chk("t6_rst_pops", {6'd0, s_pop1, s_pop0}, 8'd0);
        cycle();
        chk("t6_nopush", {6'd0, s_push1, s_push0}, 8'd0);
        chk("t6_data", {2'd0, s_data}, 8'd0);
        chk("t6_gs", {6'd0, s_gs}, 8'd0);
        rst = 1'b0;
        cycle();
        chk("t6_vc0_first", {6'd0, s_pop1, s_pop0}, 8'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
